// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit 7-segment display.
// A per-frame snapshot keeps every frame tear-free; each digit slot starts
// with a blanking gap, and digit enables, leading-zero suppression and
// decimal points are all applied to the snapshot values.
module display_scan_ctrl #(
    parameter int unsigned NDIGITS   = 8,
    parameter int unsigned DW        = 4,
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned ACT_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NDIGITS*DW-1:0] digits,
    input  logic [NDIGITS-1:0]    dp_in,
    input  logic [NDIGITS-1:0]    digit_en,
    input  logic                  lzs,
    output logic [NDIGITS-1:0]    anode,
    output logic [DW-1:0]         nibble,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int unsigned IW = $clog2(NDIGITS);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;

    // Inactive levels; XOR with these converts active-high to board polarity.
    localparam logic [NDIGITS-1:0] AN_OFF = (ACT_LOW != 0) ? '1 : '0;
    localparam logic               DP_OFF = (ACT_LOW != 0);

    logic [CW-1:0]         div_q, div_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [BW-1:0]         blank_q, blank_d;
    logic [NDIGITS*DW-1:0] snap_dig_q, snap_dig_d;
    logic [NDIGITS-1:0]    snap_dp_q, snap_dp_d;
    logic [NDIGITS-1:0]    snap_en_q, snap_en_d;
    logic                  snap_lzs_q, snap_lzs_d;
    logic                  first_q;
    logic [NDIGITS-1:0]    anode_q, anode_d;
    logic [DW-1:0]         nibble_q, nibble_d;
    logic                  dp_q, dp_d;
    logic                  fs_q, fs_d;

    logic                  tick;
    logic                  wrap;
    logic                  lit;
    logic [IW-1:0]         msd;
    logic [NDIGITS-1:0]    vis;
    logic [NDIGITS-1:0]    act;

    // Slot divider, digit index, blanking countdown and frame snapshot.
    always_comb begin
        tick       = (div_q == CW'(TICK_DIV - 1));
        wrap       = tick && (idx_q == IW'(NDIGITS - 1));
        div_d      = tick ? '0 : div_q + 1'b1;
        idx_d      = idx_q;
        blank_d    = blank_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_en_d  = snap_en_q;
        snap_lzs_d = snap_lzs_q;
        fs_d       = wrap;
        if (tick) begin
            idx_d   = wrap ? '0 : idx_q + 1'b1;
            blank_d = BW'(BLANK_CYC);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end
        // Inputs are only sampled here, so mid-frame changes wait for the next frame.
        if (first_q || wrap) begin
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
            snap_en_d  = digit_en;
            snap_lzs_d = lzs;
        end
    end

    // Visibility: enable mask combined with leading-zero suppression.
    always_comb begin
        msd = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (snap_dig_q[i*DW +: DW] != '0) msd = IW'(i);
        end
        vis = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            vis[i] = snap_en_q[i] & ~(snap_lzs_q & (IW'(i) > msd));
        end
    end

    // Output drive for the current slot, one cycle behind idx/blank.
    always_comb begin
        lit        = (blank_q == '0) && vis[idx_q];
        act        = '0;
        act[idx_q] = lit;
        anode_d    = act ^ AN_OFF;
        dp_d       = (lit && snap_dp_q[idx_q]) ? ~DP_OFF : DP_OFF;
        nibble_d   = snap_dig_q[idx_q*DW +: DW];
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q      <= '0;
            idx_q      <= '0;
            blank_q    <= BW'(BLANK_CYC);
            snap_dig_q <= '0;
            snap_dp_q  <= '0;
            snap_en_q  <= '0;
            snap_lzs_q <= 1'b0;
            first_q    <= 1'b1;
            anode_q    <= AN_OFF;
            nibble_q   <= '0;
            dp_q       <= DP_OFF;
            fs_q       <= 1'b0;
        end else begin
            div_q      <= div_d;
            idx_q      <= idx_d;
            blank_q    <= blank_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            snap_en_q  <= snap_en_d;
            snap_lzs_q <= snap_lzs_d;
            first_q    <= 1'b0;
            anode_q    <= anode_d;
            nibble_q   <= nibble_d;
            dp_q       <= dp_d;
            fs_q       <= fs_d;
        end
    end

    assign anode       = anode_q;
    assign nibble      = nibble_q;
    assign dp          = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a time-based model of the scan pattern checked
// every cycle, plus directed literal expectations at chosen cycles.
module tb_display_scan_ctrl;

    localparam int unsigned N  = 8;
    localparam int unsigned TD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned FRAME = N * TD;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        lzs;
    logic [7:0]  anode;
    logic [3:0]  nibble;
    logic        dp;
    logic        frame_start;

    int vectors     = 0;
    int miscompares = 0;

    display_scan_ctrl #(
        .NDIGITS  (N),
        .DW       (4),
        .TICK_DIV (TD),
        .BLANK_CYC(BC),
        .ACT_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .lzs        (lzs),
        .anode      (anode),
        .nibble     (nibble),
        .dp         (dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Model: outputs follow from the cycle count since reset release.
    int          model_k = 0;
    logic        model_ok = 1'b0;
    logic [31:0] m_dig;
    logic [7:0]  m_dp, m_en;
    logic        m_lzs;
    logic [7:0]  exp_anode;
    logic [3:0]  exp_nib;
    logic        exp_dp, exp_fs;

    always @(posedge clk) begin
        if (reset) begin
            model_k   = 0;
            model_ok  = 1'b1;
            m_dig     = '0;
            m_dp      = '0;
            m_en      = '0;
            m_lzs     = 1'b0;
            exp_anode = 8'hFF;
            exp_nib   = 4'h0;
            exp_dp    = 1'b1;
            exp_fs    = 1'b0;
        end else if (model_ok) begin
            int p, s, ph, msd;
            logic on;
            logic [7:0] one;
            model_k = model_k + 1;
            p   = model_k - 1;
            s   = (p / TD) % N;
            ph  = p % TD;
            msd = 0;
            for (int i = 0; i < N; i++) if (m_dig[i*4 +: 4] != 4'h0) msd = i;
            on  = (ph >= BC) && m_en[s] && !(m_lzs && (s > msd));
            one = 8'd1;
            exp_anode = on ? ~(one << s) : 8'hFF;
            exp_nib   = m_dig[s*4 +: 4];
            exp_dp    = !(on && m_dp[s]);
            exp_fs    = (model_k % FRAME) == 0;
            if (model_k == 1 || (model_k % FRAME) == 0) begin
                m_dig = digits;
                m_dp  = dp_in;
                m_en  = digit_en;
                m_lzs = lzs;
            end
        end
    end

    // Per-cycle comparison against the model, plus the one-hot invariant.
    always @(negedge clk) begin
        if (model_ok) begin
            vectors = vectors + 1;
            if (anode !== exp_anode || nibble !== exp_nib || dp !== exp_dp ||
                frame_start !== exp_fs) begin
                miscompares = miscompares + 1;
                $display("FAIL model k=%0d: anode %h/%h nibble %h/%h dp %b/%b fs %b/%b (got/expected)",
                         model_k, anode, exp_anode, nibble, exp_nib, dp, exp_dp,
                         frame_start, exp_fs);
            end
            vectors = vectors + 1;
            if ($countones(~anode) > 1) begin
                miscompares = miscompares + 1;
                $display("FAIL onehot k=%0d: anode %h has more than one active bit", model_k, anode);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        vectors = vectors + 1;
        if (got !== want) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic chk_out(input string nm, input logic [7:0] an, input logic [3:0] nb, input logic d);
        chk({nm, " anode"}, 32'(anode), 32'(an));
        chk({nm, " nibble"}, 32'(nibble), 32'(nb));
        chk({nm, " dp"}, 32'(dp), 32'(d));
    endtask

    // Advance to the negedge following model cycle n (bounded).
    task automatic at_k(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (model_k != n && guard < 500);
        if (model_k != n) begin
            vectors     = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL at_k: reached k=%0d expected %0d", model_k, n);
        end
    endtask

    // Hold reset for n edges, check reset outputs, then release.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        chk_out("reset", 8'hFF, 4'h0, 1'b1);
        chk("reset fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        digits   = 32'h76543210;
        digit_en = 8'hFF;
        dp_in    = 8'h00;
        lzs      = 1'b0;

        // Reset and basic scan.
        do_reset(3);
        at_k(1);  chk_out("s0 blank", 8'hFF, 4'h0, 1'b1);
        at_k(2);  chk_out("s0 lit",   8'hFE, 4'h0, 1'b1);
        at_k(5);  chk("s1 blank", 32'(anode), 32'hFF);
        at_k(6);  chk_out("s1 lit",   8'hFD, 4'h1, 1'b1);
        at_k(30); chk_out("s7 lit",   8'h7F, 4'h7, 1'b1);
        at_k(32); chk("fs pulse", 32'(frame_start), 32'd1);
        at_k(33); chk("fs low", 32'(frame_start), 32'd0);

        // Tear-free: change digits during slot 3 of the second frame.
        at_k(45); digits = 32'hFFFFFFFF;
        at_k(50); chk_out("tear s4", 8'hEF, 4'h4, 1'b1);
        at_k(62); chk_out("tear s7", 8'h7F, 4'h7, 1'b1);
        at_k(64); chk("fs pulse2", 32'(frame_start), 32'd1);
        at_k(66); chk_out("new frame s0", 8'hFE, 4'hF, 1'b1);
        at_k(80);

        // Leading-zero suppression.
        digits = 32'h00000120;
        lzs    = 1'b1;
        do_reset(2);
        at_k(2);  chk_out("lzs d0", 8'hFE, 4'h0, 1'b1);
        at_k(6);  chk_out("lzs d1", 8'hFD, 4'h2, 1'b1);
        at_k(10); chk_out("lzs d2", 8'hFB, 4'h1, 1'b1);
        at_k(14); chk_out("lzs d3", 8'hFF, 4'h0, 1'b1);
        at_k(32);
        digits = 32'h00000000;
        do_reset(2);
        at_k(2);  chk_out("zero d0", 8'hFE, 4'h0, 1'b1);
        at_k(6);  chk_out("zero d1", 8'hFF, 4'h0, 1'b1);
        at_k(34);

        // Enable mask and decimal point.
        digits   = 32'h76543210;
        lzs      = 1'b0;
        digit_en = 8'h0F;
        dp_in    = 8'h02;
        do_reset(2);
        at_k(2);  chk_out("mask d0", 8'hFE, 4'h0, 1'b1);
        at_k(6);  chk_out("mask d1", 8'hFD, 4'h1, 1'b0);
        at_k(10); chk_out("mask d2", 8'hFB, 4'h2, 1'b1);
        at_k(18); chk_out("mask d4", 8'hFF, 4'h4, 1'b1);

        // Reset mid-frame during slot 5.
        at_k(22);
        do_reset(1);
        at_k(1);  chk("restart blank", 32'(anode), 32'hFF);
        at_k(2);  chk_out("restart d0", 8'hFE, 4'h0, 1'b1);
        at_k(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
